// File: rtl/dt_req_stage_if.sv
// Data-memory request channel between the EX->DT stage and the data memory.
// The stage drives the request as master; the memory answers with gnt/rvalid/rdata.
interface dt_req_stage_if #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32,
    parameter int SEL_WD  = DATA_WD / 8
);
    logic               mem_req;
    logic               mem_wen;
    logic [SEL_WD-1:0]  mem_sel;
    logic [ADDR_WD-1:0] mem_addr;
    logic [DATA_WD-1:0] mem_wdata;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [DATA_WD-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_sel, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_sel, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dt_req_stage.sv
// EX->DT pipeline register with a variable-latency data-memory request engine.
// Optional misaligned-access rejection is compiled in with DT_MISALIGN_CHK_EN.
module dt_req_stage #(
    parameter int PAYLOAD_WD = 76,
    parameter int ADDR_WD    = 32,
    parameter int DATA_WD    = 32,
    parameter int SEL_WD     = DATA_WD / 8,
    parameter int STALL_WD   = 6,
    parameter int STAGE_IDX  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [STALL_WD-1:0]   stall,
    input  logic [PAYLOAD_WD-1:0] ex_payload,
    input  logic                  ex_mem_en,
    input  logic                  ex_mem_wen,
    input  logic [SEL_WD-1:0]     ex_mem_sel,
    input  logic [ADDR_WD-1:0]    ex_mem_addr,
    input  logic [DATA_WD-1:0]    ex_mem_wdata,
    dt_req_stage_if.master        mem,
    output logic [PAYLOAD_WD-1:0] dc_payload,
    output logic [DATA_WD-1:0]    dc_rdata,
    output logic                  stallreq
`ifdef DT_MISALIGN_CHK_EN
    ,
    output logic                  misalign,
    output logic [ADDR_WD-1:0]    bad_addr
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic               wen;
        logic [SEL_WD-1:0]  sel;
        logic [ADDR_WD-1:0] addr;
        logic [DATA_WD-1:0] wdata;
    } req_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [PAYLOAD_WD-1:0] payload_r;
    logic [PAYLOAD_WD-1:0] payload_nx_s;
    req_t                  req_r;
    req_t                  req_nx_s;
    logic [DATA_WD-1:0]    dc_rdata_r;
    logic [DATA_WD-1:0]    dc_rdata_nx_s;
    logic [PAYLOAD_WD-1:0] dc_payload_r;
    logic                  mem_req_r;
    logic                  stallreq_r;

    logic                  stop_own_s;
    logic                  stop_next_s;
    logic                  idle_clr_s;
    logic                  idle_cap_s;
    logic                  mis_chk_s;
    logic                  unused_stall_s;

    assign stop_own_s     = stall[STAGE_IDX];
    assign stop_next_s    = stall[STAGE_IDX+1];
    assign unused_stall_s = ^stall;

    // Flush outranks bubble, bubble outranks capture; all only act while IDLE.
    assign idle_clr_s = (state_r == ST_IDLE) && (flush || (stop_own_s && !stop_next_s));
    assign idle_cap_s = (state_r == ST_IDLE) && !flush && !stop_own_s;

`ifdef DT_MISALIGN_CHK_EN
    logic                  misalign_r;
    logic                  misalign_nx_s;
    logic [ADDR_WD-1:0]    bad_addr_r;
    logic [ADDR_WD-1:0]    bad_addr_nx_s;

    function automatic logic [7:0] count_ones(input logic [SEL_WD-1:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < SEL_WD; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

    assign mis_chk_s = ((count_ones(ex_mem_sel) == 8'd4) && (ex_mem_addr[1:0] != 2'b00)) ||
                       ((count_ones(ex_mem_sel) == 8'd2) && (ex_mem_addr[0] != 1'b0));

    // Next value of the misalignment flag and offending address.
    always_comb begin
        misalign_nx_s = misalign_r;
        bad_addr_nx_s = bad_addr_r;
        if (idle_clr_s) begin
            misalign_nx_s = 1'b0;
            bad_addr_nx_s = '0;
        end else if (idle_cap_s) begin
            misalign_nx_s = mis_chk_s;
            bad_addr_nx_s = mis_chk_s ? ex_mem_addr : '0;
        end else begin
            misalign_nx_s = misalign_r;
            bad_addr_nx_s = bad_addr_r;
        end
    end

    // Misalignment registers travel alongside payload_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_r <= 1'b0;
            bad_addr_r <= '0;
        end else begin
            misalign_r <= misalign_nx_s;
            bad_addr_r <= bad_addr_nx_s;
        end
    end

    assign misalign = misalign_r;
    assign bad_addr = bad_addr_r;
`else
    assign mis_chk_s = 1'b0;
`endif

    // Next-state and next-register computation for the request engine.
    always_comb begin
        state_nx_s    = state_r;
        payload_nx_s  = payload_r;
        req_nx_s      = req_r;
        dc_rdata_nx_s = dc_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (idle_clr_s) begin
                    payload_nx_s = '0;
                    req_nx_s     = '0;
                    state_nx_s   = ST_IDLE;
                end else if (idle_cap_s) begin
                    payload_nx_s = ex_payload;
                    req_nx_s     = {ex_mem_wen, ex_mem_sel, ex_mem_addr, ex_mem_wdata};
                    state_nx_s   = (ex_mem_en && !mis_chk_s) ? ST_REQ : ST_IDLE;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.mem_gnt) begin
                    // A granted store is committed even when flushed.
                    if (req_r.wen) begin
                        state_nx_s = ST_IDLE;
                    end else if (flush) begin
                        state_nx_s = ST_DRAIN;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                    if (flush) begin
                        payload_nx_s = '0;
                        req_nx_s     = '0;
                    end else begin
                        payload_nx_s = payload_r;
                    end
                end else if (flush) begin
                    payload_nx_s = '0;
                    req_nx_s     = '0;
                    state_nx_s   = ST_IDLE;
                end else begin
                    state_nx_s   = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_nx_s = ST_IDLE;
                    if (flush) begin
                        payload_nx_s  = '0;
                        req_nx_s      = '0;
                    end else begin
                        dc_rdata_nx_s = mem.mem_rdata;
                    end
                end else if (flush) begin
                    payload_nx_s = '0;
                    req_nx_s     = '0;
                    state_nx_s   = ST_DRAIN;
                end else begin
                    state_nx_s   = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                // The orphaned response is swallowed; flushes here change nothing.
                if (mem.mem_rvalid) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                payload_nx_s = '0;
                req_nx_s     = '0;
                state_nx_s   = ST_IDLE;
            end
        endcase
    end

    // State, pipeline registers and registered outputs derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            payload_r    <= '0;
            req_r        <= '0;
            dc_rdata_r   <= '0;
            dc_payload_r <= '0;
            mem_req_r    <= 1'b0;
            stallreq_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            payload_r    <= payload_nx_s;
            req_r        <= req_nx_s;
            dc_rdata_r   <= dc_rdata_nx_s;
            dc_payload_r <= (state_nx_s == ST_IDLE) ? payload_nx_s : '0;
            mem_req_r    <= (state_nx_s == ST_REQ);
            stallreq_r   <= (state_nx_s != ST_IDLE);
        end
    end

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_wen   = req_r.wen;
    assign mem.mem_sel   = req_r.sel;
    assign mem.mem_addr  = req_r.addr;
    assign mem.mem_wdata = req_r.wdata;

    assign dc_payload = dc_payload_r;
    assign dc_rdata   = dc_rdata_r;
    assign stallreq   = stallreq_r;

endmodule

// File: tb/tb_dt_req_stage.sv
// Scoreboard bench for dt_req_stage: stimulus queues expected outputs and memory
// requests; a negedge monitor pops and compares them as the DUT presents them.
module tb_dt_req_stage;
    localparam int PW = 76;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam logic [5:0] HOLD = 6'b110000;

    localparam logic [PW-1:0] P1 = {12'hA01, 64'h1111_2222_3333_4444};
    localparam logic [PW-1:0] P2 = {12'hB02, 64'h5555_6666_7777_8888};
    localparam logic [PW-1:0] P3 = {12'hC03, 64'h9999_AAAA_BBBB_CCCC};
    localparam logic [PW-1:0] P4 = {12'hD04, 64'hDDDD_EEEE_FFFF_0001};
    localparam logic [PW-1:0] P5 = {12'hE05, 64'h0123_4567_89AB_CDEF};
    localparam logic [PW-1:0] P6 = {12'hF06, 64'hFEDC_BA98_7654_3210};

    logic          clk = 1'b0;
    logic          rst, flush;
    logic [5:0]    stall;
    logic [PW-1:0] ex_payload;
    logic          ex_mem_en, ex_mem_wen;
    logic [SW-1:0] ex_mem_sel;
    logic [AW-1:0] ex_mem_addr;
    logic [DW-1:0] ex_mem_wdata;
    logic [PW-1:0] dc_payload;
    logic [DW-1:0] dc_rdata;
    logic          stallreq;
`ifdef DT_MISALIGN_CHK_EN
    logic          misalign;
    logic [AW-1:0] bad_addr;
`endif

    dt_req_stage_if #(.ADDR_WD(AW), .DATA_WD(DW)) mem_if ();

    dt_req_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .stall        (stall),
        .ex_payload   (ex_payload),
        .ex_mem_en    (ex_mem_en),
        .ex_mem_wen   (ex_mem_wen),
        .ex_mem_sel   (ex_mem_sel),
        .ex_mem_addr  (ex_mem_addr),
        .ex_mem_wdata (ex_mem_wdata),
        .mem          (mem_if),
        .dc_payload   (dc_payload),
        .dc_rdata     (dc_rdata),
        .stallreq     (stallreq)
`ifdef DT_MISALIGN_CHK_EN
        ,
        .misalign     (misalign),
        .bad_addr     (bad_addr)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   cyc;
        logic [127:0]  tag;
        logic          sr;
        logic          mr;
        logic [PW-1:0] pl;
        logic [DW-1:0] rd;
        logic          ck;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic          mis;
        logic [AW-1:0] bad;
    } exp_t;

    typedef struct {
        logic          wen;
        logic [SW-1:0] sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_exp_t;

    exp_t     exp_q[$];
    req_exp_t req_q[$];
    int       n_cmp = 0;
    int       n_err = 0;
    logic     end_chk = 1'b0;
    logic     end_done = 1'b0;
    logic [DW-1:0] last_rd;

    task automatic push_exp(input int unsigned off, input logic [127:0] tag, input logic sr,
                            input logic mr, input logic [PW-1:0] pl, input logic ck,
                            input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                            input logic mis, input logic [AW-1:0] bad);
        exp_t e;
        e.cyc = cyc + off; e.tag = tag; e.sr = sr; e.mr = mr; e.pl = pl; e.rd = last_rd;
        e.ck = ck; e.ad = ad; e.wd = wd; e.mis = mis; e.bad = bad;
        exp_q.push_back(e);
    endtask

    task automatic exp_o(input int unsigned off, input logic [127:0] tag, input logic sr,
                         input logic mr, input logic [PW-1:0] pl);
        push_exp(off, tag, sr, mr, pl, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic push_req(input logic wen, input logic [SW-1:0] sel,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_exp_t r;
        r.wen = wen; r.sel = sel; r.addr = addr; r.wdata = wdata;
        req_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stall = HOLD; ex_mem_en = 1'b0; flush = 1'b0;
        mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0;
    endtask

    task automatic cap(input logic [PW-1:0] pl, input logic en, input logic wen,
                       input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
        stall = 6'b000000; ex_payload = pl; ex_mem_en = en; ex_mem_wen = wen;
        ex_mem_sel = sel; ex_mem_addr = addr; ex_mem_wdata = wdata;
    endtask

    // Monitor: memory handshakes and per-cycle DC-side observations.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_if.mem_req && mem_if.mem_gnt) begin
                n_cmp++;
                if (req_q.size() == 0) begin
                    n_err++;
                    $display("FAIL req_unexpected: got wen=%b addr=%h, wanted no request",
                             mem_if.mem_wen, mem_if.mem_addr);
                end else begin
                    req_exp_t r;
                    r = req_q.pop_front();
                    if (mem_if.mem_wen !== r.wen || mem_if.mem_sel !== r.sel ||
                        mem_if.mem_addr !== r.addr || (r.wen && mem_if.mem_wdata !== r.wdata)) begin
                        n_err++;
                        $display("FAIL req_fields: got wen=%b sel=%h addr=%h wdata=%h, wanted wen=%b sel=%h addr=%h wdata=%h",
                                 mem_if.mem_wen, mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata,
                                 r.wen, r.sel, r.addr, r.wdata);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                logic ok;
                e = exp_q.pop_front();
                n_cmp++;
                ok = (e.cyc == cyc) && (stallreq === e.sr) && (mem_if.mem_req === e.mr) &&
                     (dc_payload === e.pl) && (dc_rdata === e.rd);
                if (e.ck && (mem_if.mem_addr !== e.ad || mem_if.mem_wdata !== e.wd)) ok = 1'b0;
`ifdef DT_MISALIGN_CHK_EN
                if (misalign !== e.mis || bad_addr !== e.bad) ok = 1'b0;
`endif
                if (!ok) begin
                    n_err++;
                    $display("FAIL %0s: cyc %0d/%0d got sr=%b mr=%b pl=%h rd=%h addr=%h wd=%h, wanted sr=%b mr=%b pl=%h rd=%h addr=%h wd=%h mis=%b bad=%h",
                             e.tag, cyc, e.cyc, stallreq, mem_if.mem_req, dc_payload, dc_rdata,
                             mem_if.mem_addr, mem_if.mem_wdata, e.sr, e.mr, e.pl, e.rd,
                             e.ad, e.wd, e.mis, e.bad);
                end
            end
            if (end_chk && !end_done) begin
                n_cmp++;
                if (exp_q.size() != 0 || req_q.size() != 0) begin
                    n_err++;
                    $display("FAIL drain: got %0d outputs and %0d requests left, wanted 0 and 0",
                             exp_q.size(), req_q.size());
                end
                end_done = 1'b1;
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        rst = 1'b1; flush = 1'b0; stall = HOLD; ex_payload = '0; ex_mem_en = 1'b0;
        ex_mem_wen = 1'b0; ex_mem_sel = 4'h0; ex_mem_addr = 32'd0; ex_mem_wdata = 32'd0;
        mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'd0;
        last_rd = 32'd0;

        step(); exp_o(0, "reset", 1'b0, 1'b0, '0);
        step(); rst = 1'b0;

        // Load with zero-wait memory.
        step(); cap(P1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        push_req(1'b0, 4'hF, 32'h100, 32'h0);
        exp_o(1, "ld_req", 1'b1, 1'b1, '0);
        step(); idle_in(); mem_if.mem_gnt = 1'b1; exp_o(1, "ld_wait", 1'b1, 1'b0, '0);
        step(); mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF;
        last_rd = 32'hDEADBEEF; exp_o(1, "ld_done", 1'b0, 1'b0, P1);
        step(); mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'd0;

        // Store with grant delayed three cycles; request must hold stable.
        cap(P2, 1'b1, 1'b1, 4'hF, 32'h204, 32'h12345678);
        push_req(1'b1, 4'hF, 32'h204, 32'h12345678);
        for (int k = 1; k <= 4; k++)
            push_exp(k, "st_req", 1'b1, 1'b1, '0, 1'b1, 32'h204, 32'h12345678, 1'b0, 32'd0);
        exp_o(5, "st_done", 1'b0, 1'b0, P2);
        step(); idle_in(); ex_mem_addr = 32'hFFFF_FFFC; ex_mem_wdata = 32'hA5A5A5A5;
        step(); step();
        step(); mem_if.mem_gnt = 1'b1;
        step(); mem_if.mem_gnt = 1'b0;

        // Bubble insertion.
        stall = 6'b010000; ex_mem_en = 1'b1; ex_payload = P3; ex_mem_addr = 32'h300;
        exp_o(1, "bubble", 1'b0, 1'b0, '0);
        step(); idle_in(); exp_o(1, "bubble_hold", 1'b0, 1'b0, '0);

        // Flush in REQ before grant.
        step(); cap(P3, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0); exp_o(1, "fr_req", 1'b1, 1'b1, '0);
        step(); idle_in(); flush = 1'b1; exp_o(1, "fr_idle", 1'b0, 1'b0, '0);
        step(); flush = 1'b0; exp_o(1, "fr_stay", 1'b0, 1'b0, '0);

        // Flush in WAIT, response two cycles later is drained.
        step(); cap(P4, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
        push_req(1'b0, 4'hF, 32'h400, 32'h0); exp_o(1, "fw_req", 1'b1, 1'b1, '0);
        step(); idle_in(); mem_if.mem_gnt = 1'b1; exp_o(1, "fw_wait", 1'b1, 1'b0, '0);
        step(); mem_if.mem_gnt = 1'b0; flush = 1'b1; exp_o(1, "fw_drain", 1'b1, 1'b0, '0);
        step(); exp_o(1, "fw_drain2", 1'b1, 1'b0, '0);
        step(); flush = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hCAFEF00D;
        exp_o(1, "fw_idle", 1'b0, 1'b0, '0);
        step(); mem_if.mem_rvalid = 1'b0; exp_o(1, "fw_keep", 1'b0, 1'b0, '0);

        // Capture without access, then granted store hit by flush, then flush over capture.
        step(); cap(P5, 1'b0, 1'b0, 4'hF, 32'h500, 32'h0); exp_o(1, "nomem", 1'b0, 1'b0, P5);
        step(); cap(P6, 1'b1, 1'b1, 4'h3, 32'h600, 32'h0000BEEF);
        push_req(1'b1, 4'h3, 32'h600, 32'h0000BEEF); exp_o(1, "stfl_req", 1'b1, 1'b1, '0);
        step(); idle_in(); mem_if.mem_gnt = 1'b1; flush = 1'b1; exp_o(1, "stfl_idle", 1'b0, 1'b0, '0);
        step(); cap(P1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0); mem_if.mem_gnt = 1'b0; flush = 1'b1;
        exp_o(1, "fl_cap", 1'b0, 1'b0, '0);
        step(); idle_in(); exp_o(1, "fl_cap2", 1'b0, 1'b0, '0);

        // Flush together with rvalid in WAIT discards the data.
        step(); cap(P2, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
        push_req(1'b0, 4'hF, 32'h700, 32'h0); exp_o(1, "fwr_req", 1'b1, 1'b1, '0);
        step(); idle_in(); mem_if.mem_gnt = 1'b1; exp_o(1, "fwr_wait", 1'b1, 1'b0, '0);
        step(); mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; flush = 1'b1;
        mem_if.mem_rdata = 32'h0BAD0BAD; exp_o(1, "fwr_idle", 1'b0, 1'b0, '0);
        step(); idle_in();

`ifdef DT_MISALIGN_CHK_EN
        // Misaligned word load is rejected at capture.
        cap(P3, 1'b1, 1'b0, 4'hF, 32'h102, 32'h0);
        push_exp(1, "mis", 1'b0, 1'b0, P3, 1'b0, 32'd0, 32'd0, 1'b1, 32'h102);
        step(); idle_in(); mem_if.mem_gnt = 1'b1;
        push_exp(1, "mis_hold", 1'b0, 1'b0, P3, 1'b0, 32'd0, 32'd0, 1'b1, 32'h102);
        step(); mem_if.mem_gnt = 1'b0; flush = 1'b1;
        exp_o(1, "mis_clr", 1'b0, 1'b0, '0);
        step(); flush = 1'b0;
`endif

        // Reset while WAIT; a late response must be ignored.
        cap(P4, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
        push_req(1'b0, 4'hF, 32'h800, 32'h0); exp_o(1, "rw_req", 1'b1, 1'b1, '0);
        step(); idle_in(); mem_if.mem_gnt = 1'b1; exp_o(1, "rw_wait", 1'b1, 1'b0, '0);
        step(); mem_if.mem_gnt = 1'b0; rst = 1'b1; last_rd = 32'd0;
        exp_o(1, "rw_rst", 1'b0, 1'b0, '0);
        step(); rst = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h5555AAAA;
        exp_o(1, "rw_ign", 1'b0, 1'b0, '0);
        step(); mem_if.mem_rvalid = 1'b0;

        step(); end_chk = 1'b1;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dt_req_stage.md
Name: dt_req_stage

Overview:
- Parametrised EX->DT pipeline register with a data-memory request engine.
- Latches the EX payload and the data-memory request, then issues the request over a req/gnt/rvalid handshake that tolerates variable latency.
- Raises stallreq until the access completes and presents payload plus load data to DC.
- Handles flush, stall and bubble insertion, including a flush that arrives while a load is outstanding.

Parameters:
- PAYLOAD_WD, 76, width of EX->DC sideband payload.
- ADDR_WD, 32, data address width.
- DATA_WD, 32, data width (multiple of 8).
- SEL_WD, DATA_WD/8, byte-select width.
- STALL_WD, 6, width of stall vector.
- STAGE_IDX, 4, stall bit owning this register; STAGE_IDX+1 < STALL_WD.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush.
- stall  in  STALL_WD  stall vector, 1 = Stop.
- ex_payload  in  PAYLOAD_WD  EX payload.
- ex_mem_en  in  1  memory access request.
- ex_mem_wen  in  1  1 = store, 0 = load.
- ex_mem_sel  in  SEL_WD  byte enables.
- ex_mem_addr  in  ADDR_WD  byte address.
- ex_mem_wdata  in  DATA_WD  store data.
- mem_req  out  1  request valid.
- mem_wen  out  1  request is a store.
- mem_sel  out  SEL_WD  byte enables.
- mem_addr  out  ADDR_WD  address.
- mem_wdata  out  DATA_WD  store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid; never asserted in the same cycle as the matching gnt.
- mem_rdata  in  DATA_WD  load data.
- dc_payload  out  PAYLOAD_WD  payload to DC; all-zero while busy.
- dc_rdata  out  DATA_WD  captured load data.
- stallreq  out  1  stage busy; controller must Stop bits 0..STAGE_IDX.

Behaviour:
- Reset: all registers zero, state IDLE. Outputs zero: mem_req=0, stallreq=0, dc_payload=0, dc_rdata=0.
- States:
  - IDLE.
  - REQ: mem_req=1.
  - WAIT: load granted, awaiting rvalid.
  - DRAIN: flushed load awaiting rvalid.
- busy = state != IDLE.
- stallreq = busy.
- dc_payload = busy ? 0 : payload_r.
- Register update priority on each posedge, only when state is IDLE:
  1. rst.
  2. flush -> payload_r/req_r <= 0.
  3. stall[STAGE_IDX]=Stop & stall[STAGE_IDX+1]=NoStop -> bubble (zero).
  4. stall[STAGE_IDX]=NoStop -> capture ex_*.
  5. Otherwise hold.
- When not IDLE, payload_r and req_r hold regardless of stall.
- On a capture with ex_mem_en=1: state <= REQ; mem_req asserts the next cycle.
  - Capture with ex_mem_en=0 stays IDLE; payload is visible to DC with no access.
- REQ:
  - mem_* driven from req_r, held stable until gnt.
  - gnt & store -> IDLE; the store completes at gnt.
  - gnt & load -> WAIT.
  - flush in REQ without gnt -> request withdrawn, payload cleared, IDLE.
  - flush in REQ with gnt & load -> DRAIN.
  - flush in REQ with gnt & store -> IDLE, payload cleared; the store is committed.
- WAIT:
  - rvalid -> dc_rdata <= mem_rdata, IDLE; dc_payload is shown from the next cycle.
  - flush & !rvalid -> DRAIN, payload cleared.
  - flush & rvalid -> IDLE, payload cleared, data discarded.
- DRAIN:
  - rvalid consumed and discarded, then IDLE.
  - stallreq=1; further flushes have no additional effect.
- dc_rdata holds its last value until the next load response.
- Latency:
  - Store: 1 + grant wait.
  - Load: 1 + grant wait + response wait.
  - Zero-wait memory: load completes 3 cycles after capture (REQ, WAIT, IDLE).
- rst at any state (including DRAIN) -> IDLE immediately. A pending response arriving later is ignored because rvalid is only sampled in WAIT/DRAIN.

Optional Feature:
- Macro: DT_MISALIGN_CHK_EN.
- When defined:
  - At capture, an access is misaligned if:
    - sel has 4 bits set and addr[1:0]!=0, or
    - sel has 2 bits set and addr[0]!=0.
  - A misaligned access never enters REQ.
  - Extra output misalign (1 bit) is registered alongside payload_r, so DC sees it in the cycle after capture.
  - Extra output bad_addr (ADDR_WD) holds the offending address.
  - Both are cleared by rst, flush and bubble.
- When not defined: no check, no extra ports, and all ex_mem_en captures enter REQ.

Test Plan:
- Load, zero-wait memory: capture addr=0x100, gnt same cycle as req, rvalid next cycle with 0xDEADBEEF -> stallreq high 2 cycles, then dc_rdata=0xDEADBEEF and dc_payload=captured payload.
- Store with gnt delayed 3 cycles: addr=0x204, wdata=0x12345678, sel=4'b1111 -> mem_* stable for 4 req cycles; IDLE after gnt; no rvalid expected.
- Bubble insertion: stall[4]=1, stall[5]=0 while IDLE -> dc_payload=0, mem_req stays 0.
- Flush in REQ before gnt -> mem_req drops next cycle, state IDLE, stallreq=0.
- Flush in WAIT, rvalid 2 cycles later with 0xCAFEF00D -> DRAIN, stallreq held; dc_rdata unchanged; IDLE after rvalid.
- With DT_MISALIGN_CHK_EN: load sel=4'b1111, addr=0x102 -> misaligned access rejected, mem_req never asserted, misalign=1, bad_addr=0x102, stallreq=0.
